// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_fsm_if;
  logic [5:0] op;
  logic       zero;
  logic       PCWre;
  logic [1:0] PCSrc;
  logic       IRWre;
  logic       RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc;
  logic       ALUSrcB;
  logic       ExtSel;
  logic [2:0] ALUOp;
  logic       mRD;
  logic       mWR;
  logic [2:0] curState;

  modport master (
    input  op,
    input  zero,
    output PCWre,
    output PCSrc,
    output IRWre,
    output RegWre,
    output RegDst,
    output WrRegDSrc,
    output ALUSrcB,
    output ExtSel,
    output ALUOp,
    output mRD,
    output mWR,
    output curState
  );

  modport slave (
    output op,
    output zero,
    input  PCWre,
    input  PCSrc,
    input  IRWre,
    input  RegWre,
    input  RegDst,
    input  WrRegDSrc,
    input  ALUSrcB,
    input  ExtSel,
    input  ALUOp,
    input  mRD,
    input  mWR,
    input  curState
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU main control FSM: IF/ID/EXE/MEM/WB sequencing
// and all datapath strobes, Moore/Mealy outputs from (state, op, zero).
module multicycle_ctrl_fsm (
  input  logic CLK,
  input  logic Reset,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_e state_q, state_d;

  logic is_add, is_sub, is_addiu, is_and;
  logic is_ori, is_slt, is_sw, is_lw;
  logic is_beq, is_bne, is_j, is_jr;
  logic is_jal, is_halt;
  logic is_alu, is_ls, is_br;

  assign is_add   = bus.op == OP_ADD;
  assign is_sub   = bus.op == OP_SUB;
  assign is_addiu = bus.op == OP_ADDIU;
  assign is_and   = bus.op == OP_AND;
  assign is_ori   = bus.op == OP_ORI;
  assign is_slt   = bus.op == OP_SLT;
  assign is_sw    = bus.op == OP_SW;
  assign is_lw    = bus.op == OP_LW;
  assign is_beq   = bus.op == OP_BEQ;
  assign is_bne   = bus.op == OP_BNE;
  assign is_j     = bus.op == OP_J;
  assign is_jr    = bus.op == OP_JR;
  assign is_jal   = bus.op == OP_JAL;
  assign is_halt  = bus.op == OP_HALT;

  assign is_alu = is_add | is_sub | is_addiu
                | is_and | is_ori | is_slt;
  assign is_ls  = is_sw | is_lw;
  assign is_br  = is_beq | is_bne;

  logic       pcwre;
  logic [1:0] pcsrc;
  logic       irwre;
  logic       regwre;
  logic [1:0] regdst;
  logic       wrsrc;
  logic       alusrcb;
  logic       extsel;
  logic [2:0] aluop;
  logic       mrd;
  logic       mwr;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcwre   = 1'b0;
    pcsrc   = 2'b00;
    irwre   = 1'b0;
    regwre  = 1'b0;
    regdst  = 2'b00;
    wrsrc   = 1'b0;
    alusrcb = 1'b0;
    extsel  = 1'b0;
    aluop   = 3'b000;
    mrd     = 1'b0;
    mwr     = 1'b0;
    unique case (state_q)
      S_IF: begin
        irwre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        state_d = S_IF;
        unique case (1'b1)
          is_j: begin
            pcsrc = 2'b11;
            pcwre = 1'b1;
          end
          is_jr: begin
            pcsrc = 2'b10;
            pcwre = 1'b1;
          end
          is_jal: begin
            pcsrc  = 2'b11;
            pcwre  = 1'b1;
            regwre = 1'b1;
            regdst = 2'b00;
            wrsrc  = 1'b0;
          end
          // PC stays frozen so HALT is refetched forever
          is_halt: pcwre = 1'b0;
          is_alu:  state_d = S_EXE_AL;
          is_ls:   state_d = S_EXE_LS;
          is_br:   state_d = S_EXE_BR;
          default: pcwre = 1'b1;
        endcase
      end
      S_EXE_AL: begin
        state_d = S_WB_AL;
        unique case (1'b1)
          is_sub: aluop = 3'b001;
          is_addiu: begin
            aluop   = 3'b000;
            alusrcb = 1'b1;
            extsel  = 1'b1;
          end
          is_and: aluop = 3'b100;
          is_ori: begin
            aluop   = 3'b101;
            alusrcb = 1'b1;
            extsel  = 1'b0;
          end
          is_slt:  aluop = 3'b010;
          default: aluop = 3'b000;
        endcase
      end
      S_WB_AL: begin
        regwre  = 1'b1;
        regdst  = (is_addiu | is_ori) ? 2'b01 : 2'b10;
        wrsrc   = 1'b0;
        pcwre   = 1'b1;
        state_d = S_IF;
      end
      S_EXE_LS: begin
        aluop   = 3'b000;
        alusrcb = 1'b1;
        extsel  = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        unique case (1'b1)
          is_sw: begin
            mwr     = 1'b1;
            pcwre   = 1'b1;
            state_d = S_IF;
          end
          is_lw: begin
            mrd     = 1'b1;
            state_d = S_WB_LD;
          end
          // IR cannot change here; retire safely without a strobe
          default: begin
            pcwre   = 1'b1;
            state_d = S_IF;
          end
        endcase
      end
      S_WB_LD: begin
        mrd     = 1'b1;
        regwre  = 1'b1;
        regdst  = 2'b01;
        wrsrc   = 1'b1;
        pcwre   = 1'b1;
        state_d = S_IF;
      end
      S_EXE_BR: begin
        aluop   = 3'b001;
        alusrcb = 1'b0;
        extsel  = 1'b1;
        pcwre   = 1'b1;
        if ((is_beq & bus.zero) | (is_bne & ~bus.zero))
          pcsrc = 2'b01;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Strobes are masked while reset is held so nothing fires on the datapath
  assign bus.PCWre     = Reset & pcwre;
  assign bus.PCSrc     = Reset ? pcsrc : 2'b00;
  assign bus.IRWre     = Reset & irwre;
  assign bus.RegWre    = Reset & regwre;
  assign bus.mRD       = Reset & mrd;
  assign bus.mWR       = Reset & mwr;
  assign bus.RegDst    = regdst;
  assign bus.WrRegDSrc = wrsrc;
  assign bus.ALUSrcB   = alusrcb;
  assign bus.ExtSel    = extsel;
  assign bus.ALUOp     = aluop;
  assign bus.curState  = state_q;

endmodule
